mips_run_ctrl: RTL and testbench

- Parametrised run/reset controller for the single-cycle MIPS core (`top`). It replaces free-running clock and one-shot reset stimulus with a controlled sequencer.
- Generates the core's active-high reset and a per-cycle clock enable.
- Supports run, single-step, external halt and PC breakpoints.
- Counts cycles and retired instructions; sits between the board or bench and the core's `clk`/`rst`.

---
 rtl/mips_run_ctrl_if.sv | 40 ++++
 rtl/mips_run_ctrl.sv | 166 ++++++++++++++++
 tb/tb_mips_run_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_run_ctrl_if.sv
// Command/status bundle between a board or bench (master) and mips_run_ctrl (slave).
// MIPS_RUN_INST_LIMIT_EN adds the limit_hit status line.
interface mips_run_ctrl_if #(
  parameter int NUM_BP = 2,
  parameter int CNT_W  = 32
);
  logic                  run;
  logic                  step;
  logic                  halt_req;
  logic                  soft_rst;
  logic [31:0]           pc;
  logic [NUM_BP*32-1:0]  bp_addr;
  logic [NUM_BP-1:0]     bp_en;
  logic                  core_rst;
  logic                  core_ce;
  logic [1:0]            state;
  logic                  halted;
  logic [NUM_BP-1:0]     bp_hit;
  logic [CNT_W-1:0]      cycle_cnt;
  logic [CNT_W-1:0]      inst_cnt;
`ifdef MIPS_RUN_INST_LIMIT_EN
  logic                  limit_hit;
`endif

  modport master (
    output run, step, halt_req, soft_rst, pc, bp_addr, bp_en,
    input  core_rst, core_ce, state, halted, bp_hit, cycle_cnt, inst_cnt
`ifdef MIPS_RUN_INST_LIMIT_EN
    , input limit_hit
`endif
  );

  modport slave (
    input  run, step, halt_req, soft_rst, pc, bp_addr, bp_en,
    output core_rst, core_ce, state, halted, bp_hit, cycle_cnt, inst_cnt
`ifdef MIPS_RUN_INST_LIMIT_EN
    , output limit_hit
`endif
  );
endinterface

// File: rtl/mips_run_ctrl.sv
// Run/reset sequencer for the single-cycle MIPS core: reset timing, run/step/halt, PC breakpoints
// and saturating cycle/instruction counters. MIPS_RUN_INST_LIMIT_EN enables the instruction limit.
module mips_run_ctrl #(
  parameter int RST_CYCLES = 4,
  parameter int NUM_BP     = 2,
  parameter int CNT_W      = 32
`ifdef MIPS_RUN_INST_LIMIT_EN
  , parameter int INST_LIMIT = 1000
`endif
) (
  input  logic           clk,
  input  logic           rst,
  mips_run_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RESET = 2'b00,
    ST_HALT  = 2'b01,
    ST_RUN   = 2'b10,
    ST_STEP  = 2'b11
  } state_t;

  localparam logic [7:0]       RST_LAST = 8'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t             state_r;
  logic               core_rst_r;
  logic               halted_r;
  logic [NUM_BP-1:0]  bp_hit_r;
  logic [CNT_W-1:0]   cycle_cnt_r;
  logic [CNT_W-1:0]   inst_cnt_r;
  logic [7:0]         rst_cnt_r;
  logic               resume_r;
  logic               limit_hit_r;

  logic [NUM_BP-1:0]  bp_raw_s;
  logic [NUM_BP-1:0]  bp_vec_s;
  logic               bp_match_s;
  logic               ce_s;
  logic               limit_stop_s;
  logic               step_block_s;

  // Per-slot PC comparators.
  always_comb begin
    bp_raw_s = {NUM_BP{1'b0}};
    for (int i = 0; i < NUM_BP; i++) begin
      bp_raw_s[i] = bus.bp_en[i] && (bus.pc == bus.bp_addr[32*i +: 32]);
    end
  end

  // The first RUN cycle after a resume must be allowed to leave a breakpoint PC.
  assign bp_vec_s   = resume_r ? {NUM_BP{1'b0}} : bp_raw_s;
  assign bp_match_s = |bp_vec_s;

  // Clock enable is decoded in the same cycle so a breakpoint PC never retires.
  always_comb begin
    ce_s = 1'b0;
    case (state_r)
      ST_RUN:  ce_s = !bus.halt_req && !bp_match_s;
      ST_STEP: ce_s = 1'b1;
      default: ce_s = 1'b0;
    endcase
  end

`ifdef MIPS_RUN_INST_LIMIT_EN
  localparam logic [CNT_W-1:0] LIMIT_LAST = CNT_W'(INST_LIMIT - 1);
  localparam logic [CNT_W-1:0] LIMIT_VAL  = CNT_W'(INST_LIMIT);
  assign limit_stop_s = (inst_cnt_r == LIMIT_LAST) && ce_s;
  assign step_block_s = (inst_cnt_r >= LIMIT_VAL);
`else
  assign limit_stop_s = 1'b0;
  assign step_block_s = 1'b0;
`endif

  // Sequencer FSM with registered status outputs and saturating counters.
  always_ff @(posedge clk) begin
    if (!rst || bus.soft_rst) begin
      state_r     <= ST_RESET;
      core_rst_r  <= 1'b1;
      halted_r    <= 1'b0;
      bp_hit_r    <= {NUM_BP{1'b0}};
      cycle_cnt_r <= {CNT_W{1'b0}};
      inst_cnt_r  <= {CNT_W{1'b0}};
      rst_cnt_r   <= 8'd0;
      resume_r    <= 1'b0;
      limit_hit_r <= 1'b0;
    end else begin
      if ((state_r != ST_RESET) && (cycle_cnt_r != CNT_MAX)) begin
        cycle_cnt_r <= cycle_cnt_r + CNT_ONE;
      end
      if (ce_s && (inst_cnt_r != CNT_MAX)) begin
        inst_cnt_r <= inst_cnt_r + CNT_ONE;
      end
      case (state_r)
        ST_RESET: begin
          if (rst_cnt_r >= RST_LAST) begin
            state_r    <= ST_HALT;
            core_rst_r <= 1'b0;
            halted_r   <= 1'b1;
            rst_cnt_r  <= 8'd0;
          end else begin
            rst_cnt_r  <= rst_cnt_r + 8'd1;
          end
        end
        ST_HALT: begin
          if (bus.run) begin
            state_r     <= ST_RUN;
            halted_r    <= 1'b0;
            resume_r    <= 1'b1;
            bp_hit_r    <= {NUM_BP{1'b0}};
            limit_hit_r <= 1'b0;
          end else if (bus.step && !step_block_s) begin
            state_r     <= ST_STEP;
            halted_r    <= 1'b0;
            bp_hit_r    <= {NUM_BP{1'b0}};
            limit_hit_r <= 1'b0;
          end else begin
            state_r     <= ST_HALT;
          end
        end
        ST_RUN: begin
          resume_r <= 1'b0;
          if (bp_match_s || bus.halt_req) begin
            state_r  <= ST_HALT;
            halted_r <= 1'b1;
            if (bp_match_s) begin
              bp_hit_r <= bp_vec_s;
            end
          end else if (limit_stop_s) begin
            state_r     <= ST_HALT;
            halted_r    <= 1'b1;
            limit_hit_r <= 1'b1;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_STEP: begin
          state_r  <= ST_HALT;
          halted_r <= 1'b1;
        end
        default: begin
          state_r    <= ST_RESET;
          core_rst_r <= 1'b1;
          halted_r   <= 1'b0;
          rst_cnt_r  <= 8'd0;
        end
      endcase
    end
  end

  assign bus.core_rst  = core_rst_r;
  assign bus.core_ce   = ce_s;
  assign bus.state     = state_r;
  assign bus.halted    = halted_r;
  assign bus.bp_hit    = bp_hit_r;
  assign bus.cycle_cnt = cycle_cnt_r;
  assign bus.inst_cnt  = inst_cnt_r;
`ifdef MIPS_RUN_INST_LIMIT_EN
  assign bus.limit_hit = limit_hit_r;
`else
  logic unused_s;
  assign unused_s = limit_hit_r ^ limit_stop_s ^ step_block_s;
`endif

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed self-checking bench for mips_run_ctrl; a second 4-bit-counter instance covers saturation.
module tb_mips_run_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mips_run_ctrl_if #(.NUM_BP(2), .CNT_W(32)) bus ();
  mips_run_ctrl_if #(.NUM_BP(2), .CNT_W(4))  bus2 ();

  mips_run_ctrl #(
    .RST_CYCLES(4), .NUM_BP(2), .CNT_W(32)
`ifdef MIPS_RUN_INST_LIMIT_EN
    , .INST_LIMIT(10)
`endif
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  mips_run_ctrl #(
    .RST_CYCLES(4), .NUM_BP(2), .CNT_W(4)
`ifdef MIPS_RUN_INST_LIMIT_EN
    , .INST_LIMIT(15)
`endif
  ) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.run = 1'b0; bus.step = 1'b0; bus.halt_req = 1'b0; bus.soft_rst = 1'b0;
    bus.pc = 32'h0; bus.bp_addr = 64'h0; bus.bp_en = 2'b00;
    bus2.run = 1'b0; bus2.step = 1'b0; bus2.halt_req = 1'b0; bus2.soft_rst = 1'b0;
    bus2.pc = 32'h0; bus2.bp_addr = 64'h0; bus2.bp_en = 2'b00;
  endtask

  task automatic restart();
    clear_inputs();
    rst = 1'b0;
    step_clk();
    step_clk();
    rst = 1'b1;
    for (int k = 0; k < 20 && bus.state !== 2'b01; k++) step_clk();
    n_cmp++; if (bus.state !== 2'b01) begin n_err++; $display("FAIL restart_halt got=%b exp=01", bus.state); end
  endtask

  task automatic test_reset();
    int cnt;
    clear_inputs();
    rst = 1'b0;
    step_clk();
    step_clk();
    n_cmp++; if (bus.state !== 2'b00) begin n_err++; $display("FAIL rst_state got=%b exp=00", bus.state); end
    n_cmp++; if (bus.core_rst !== 1'b1) begin n_err++; $display("FAIL rst_core_rst got=%b exp=1", bus.core_rst); end
    n_cmp++; if (bus.core_ce !== 1'b0) begin n_err++; $display("FAIL rst_core_ce got=%b exp=0", bus.core_ce); end
    n_cmp++; if (bus.halted !== 1'b0) begin n_err++; $display("FAIL rst_halted got=%b exp=0", bus.halted); end
    n_cmp++; if (bus.bp_hit !== 2'b00) begin n_err++; $display("FAIL rst_bp_hit got=%b exp=00", bus.bp_hit); end
    n_cmp++; if (bus.cycle_cnt !== 32'd0) begin n_err++; $display("FAIL rst_cycle_cnt got=%0d exp=0", bus.cycle_cnt); end
    rst = 1'b1;
    cnt = 0;
    for (int k = 0; k < 20 && bus.core_rst === 1'b1; k++) begin
      cnt++;
      step_clk();
    end
    n_cmp++; if (cnt !== 4) begin n_err++; $display("FAIL rst_hold_cycles got=%0d exp=4", cnt); end
    n_cmp++; if (bus.state !== 2'b01) begin n_err++; $display("FAIL rst_to_halt got=%b exp=01", bus.state); end
    n_cmp++; if (bus.halted !== 1'b1) begin n_err++; $display("FAIL rst_halted_after got=%b exp=1", bus.halted); end
    n_cmp++; if (bus.inst_cnt !== 32'd0) begin n_err++; $display("FAIL rst_inst_cnt got=%0d exp=0", bus.inst_cnt); end
    n_cmp++; if (bus.cycle_cnt !== 32'd0) begin n_err++; $display("FAIL rst_cycle_after got=%0d exp=0", bus.cycle_cnt); end
  endtask

  task automatic test_step();
    restart();
    bus.step = 1'b1;
    #1;
    n_cmp++; if (bus.core_ce !== 1'b0) begin n_err++; $display("FAIL step_halt_ce got=%b exp=0", bus.core_ce); end
    step_clk();
    bus.step = 1'b0;
    #1;
    n_cmp++; if (bus.state !== 2'b11) begin n_err++; $display("FAIL step_state got=%b exp=11", bus.state); end
    n_cmp++; if (bus.core_ce !== 1'b1) begin n_err++; $display("FAIL step_ce got=%b exp=1", bus.core_ce); end
    step_clk();
    n_cmp++; if (bus.state !== 2'b01) begin n_err++; $display("FAIL step_back_halt got=%b exp=01", bus.state); end
    n_cmp++; if (bus.core_ce !== 1'b0) begin n_err++; $display("FAIL step_ce_after got=%b exp=0", bus.core_ce); end
    n_cmp++; if (bus.inst_cnt !== 32'd1) begin n_err++; $display("FAIL step_inst got=%0d exp=1", bus.inst_cnt); end
    n_cmp++; if (bus.cycle_cnt !== 32'd2) begin n_err++; $display("FAIL step_cycle got=%0d exp=2", bus.cycle_cnt); end
    bus.run = 1'b1;
    bus.step = 1'b1;
    step_clk();
    bus.run = 1'b0;
    bus.step = 1'b0;
    #1;
    n_cmp++; if (bus.state !== 2'b10) begin n_err++; $display("FAIL step_run_prio got=%b exp=10", bus.state); end
    bus.halt_req = 1'b1;
    #1;
    n_cmp++; if (bus.core_ce !== 1'b0) begin n_err++; $display("FAIL step_halt_req_ce got=%b exp=0", bus.core_ce); end
    step_clk();
    bus.halt_req = 1'b0;
    n_cmp++; if (bus.state !== 2'b01) begin n_err++; $display("FAIL step_halted got=%b exp=01", bus.state); end
  endtask

  task automatic test_breakpoint();
    restart();
    bus.bp_addr = 64'h0000_0000_0000_000C;
    bus.bp_en = 2'b01;
    bus.pc = 32'h0;
    bus.run = 1'b1;
    step_clk();
    bus.run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.pc = 32'(4 * i);
      #1;
      n_cmp++;
      if (bus.core_ce !== (i < 3)) begin
        n_err++; $display("FAIL bp_ce pc=%h got=%b exp=%b", bus.pc, bus.core_ce, (i < 3));
      end
      step_clk();
    end
    n_cmp++; if (bus.state !== 2'b01) begin n_err++; $display("FAIL bp_state got=%b exp=01", bus.state); end
    n_cmp++; if (bus.bp_hit !== 2'b01) begin n_err++; $display("FAIL bp_hit got=%b exp=01", bus.bp_hit); end
    n_cmp++; if (bus.inst_cnt !== 32'd3) begin n_err++; $display("FAIL bp_inst got=%0d exp=3", bus.inst_cnt); end
    bus.run = 1'b1;
    step_clk();
    bus.run = 1'b0;
    #1;
    n_cmp++; if (bus.bp_hit !== 2'b00) begin n_err++; $display("FAIL bp_hit_clear got=%b exp=00", bus.bp_hit); end
    n_cmp++; if (bus.core_ce !== 1'b1) begin n_err++; $display("FAIL bp_resume_ce got=%b exp=1", bus.core_ce); end
    step_clk();
    bus.pc = 32'h10;
    #1;
    n_cmp++; if (bus.core_ce !== 1'b1) begin n_err++; $display("FAIL bp_continue_ce got=%b exp=1", bus.core_ce); end
    n_cmp++; if (bus.inst_cnt !== 32'd4) begin n_err++; $display("FAIL bp_inst_resume got=%0d exp=4", bus.inst_cnt); end
    bus.halt_req = 1'b1;
    step_clk();
    bus.halt_req = 1'b0;
    n_cmp++; if (bus.state !== 2'b01) begin n_err++; $display("FAIL bp_stop got=%b exp=01", bus.state); end
  endtask

  task automatic test_halt_req();
    restart();
    bus.pc = 32'h0;
    bus.run = 1'b1;
    step_clk();
    bus.run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.pc = 32'(4 * i);
      #1;
      n_cmp++; if (bus.core_ce !== 1'b1) begin n_err++; $display("FAIL hr_run_ce i=%0d got=%b exp=1", i, bus.core_ce); end
      step_clk();
    end
    bus.pc = 32'h10;
    bus.halt_req = 1'b1;
    #1;
    n_cmp++; if (bus.core_ce !== 1'b0) begin n_err++; $display("FAIL hr_ce got=%b exp=0", bus.core_ce); end
    step_clk();
    bus.halt_req = 1'b0;
    n_cmp++; if (bus.state !== 2'b01) begin n_err++; $display("FAIL hr_state got=%b exp=01", bus.state); end
    n_cmp++; if (bus.inst_cnt !== 32'd4) begin n_err++; $display("FAIL hr_inst got=%0d exp=4", bus.inst_cnt); end
    n_cmp++; if (bus.bp_hit !== 2'b00) begin n_err++; $display("FAIL hr_bp_hit got=%b exp=00", bus.bp_hit); end
    // Breakpoint on slot 1 coinciding with halt_req: the match must still be recorded.
    bus.bp_addr = 64'h0000_0010_0000_0000;
    bus.bp_en = 2'b10;
    bus.pc = 32'h0C;
    bus.run = 1'b1;
    step_clk();
    bus.run = 1'b0;
    step_clk();
    bus.pc = 32'h10;
    bus.halt_req = 1'b1;
    #1;
    n_cmp++; if (bus.core_ce !== 1'b0) begin n_err++; $display("FAIL hr_bp_ce got=%b exp=0", bus.core_ce); end
    step_clk();
    bus.halt_req = 1'b0;
    n_cmp++; if (bus.bp_hit !== 2'b10) begin n_err++; $display("FAIL hr_bp_both got=%b exp=10", bus.bp_hit); end
    n_cmp++; if (bus.inst_cnt !== 32'd5) begin n_err++; $display("FAIL hr_bp_inst got=%0d exp=5", bus.inst_cnt); end
  endtask

  task automatic test_soft_rst();
    int cnt;
    restart();
    bus.pc = 32'h0;
    bus.run = 1'b1;
    step_clk();
    bus.run = 1'b0;
    step_clk();
    bus.pc = 32'h4;
    step_clk();
    bus.soft_rst = 1'b1;
    step_clk();
    bus.soft_rst = 1'b0;
    #1;
    n_cmp++; if (bus.state !== 2'b00) begin n_err++; $display("FAIL srst_state got=%b exp=00", bus.state); end
    n_cmp++; if (bus.core_rst !== 1'b1) begin n_err++; $display("FAIL srst_core_rst got=%b exp=1", bus.core_rst); end
    n_cmp++; if (bus.core_ce !== 1'b0) begin n_err++; $display("FAIL srst_ce got=%b exp=0", bus.core_ce); end
    n_cmp++; if (bus.cycle_cnt !== 32'd0) begin n_err++; $display("FAIL srst_cycle got=%0d exp=0", bus.cycle_cnt); end
    n_cmp++; if (bus.inst_cnt !== 32'd0) begin n_err++; $display("FAIL srst_inst got=%0d exp=0", bus.inst_cnt); end
    step_clk();
    step_clk();
    bus.soft_rst = 1'b1;
    step_clk();
    bus.soft_rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20 && bus.core_rst === 1'b1; k++) begin
      cnt++;
      step_clk();
    end
    n_cmp++; if (cnt !== 4) begin n_err++; $display("FAIL srst_restart_cycles got=%0d exp=4", cnt); end
    n_cmp++; if (bus.state !== 2'b01) begin n_err++; $display("FAIL srst_halt got=%b exp=01", bus.state); end
  endtask

  task automatic test_saturate();
    logic [1:0] exp_state;
    restart();
    bus2.pc = 32'h0;
    bus2.run = 1'b1;
    step_clk();
    bus2.run = 1'b0;
    repeat (13) step_clk();
    n_cmp++; if (bus2.cycle_cnt !== 4'd14) begin n_err++; $display("FAIL sat_cycle_pre got=%0d exp=14", bus2.cycle_cnt); end
    n_cmp++; if (bus2.inst_cnt !== 4'd13) begin n_err++; $display("FAIL sat_inst_pre got=%0d exp=13", bus2.inst_cnt); end
    repeat (7) step_clk();
    n_cmp++; if (bus2.cycle_cnt !== 4'd15) begin n_err++; $display("FAIL sat_cycle got=%0d exp=15", bus2.cycle_cnt); end
    n_cmp++; if (bus2.inst_cnt !== 4'd15) begin n_err++; $display("FAIL sat_inst got=%0d exp=15", bus2.inst_cnt); end
`ifdef MIPS_RUN_INST_LIMIT_EN
    exp_state = 2'b01;
`else
    exp_state = 2'b10;
`endif
    n_cmp++; if (bus2.state !== exp_state) begin n_err++; $display("FAIL sat_state got=%b exp=%b", bus2.state, exp_state); end
  endtask

`ifdef MIPS_RUN_INST_LIMIT_EN
  task automatic test_inst_limit();
    restart();
    bus.pc = 32'h0;
    bus.run = 1'b1;
    step_clk();
    bus.run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.pc = 32'(4 * i);
      #1;
      n_cmp++; if (bus.core_ce !== 1'b1) begin n_err++; $display("FAIL lim_ce i=%0d got=%b exp=1", i, bus.core_ce); end
      step_clk();
    end
    n_cmp++; if (bus.state !== 2'b01) begin n_err++; $display("FAIL lim_state got=%b exp=01", bus.state); end
    n_cmp++; if (bus.inst_cnt !== 32'd10) begin n_err++; $display("FAIL lim_inst got=%0d exp=10", bus.inst_cnt); end
    n_cmp++; if (bus.limit_hit !== 1'b1) begin n_err++; $display("FAIL lim_hit got=%b exp=1", bus.limit_hit); end
    bus.step = 1'b1;
    step_clk();
    bus.step = 1'b0;
    #1;
    n_cmp++; if (bus.core_ce !== 1'b0) begin n_err++; $display("FAIL lim_step_ce got=%b exp=0", bus.core_ce); end
    n_cmp++; if (bus.state !== 2'b01) begin n_err++; $display("FAIL lim_step_state got=%b exp=01", bus.state); end
    n_cmp++; if (bus.inst_cnt !== 32'd10) begin n_err++; $display("FAIL lim_step_inst got=%0d exp=10", bus.inst_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_step();
    test_breakpoint();
    test_halt_req();
    test_soft_rst();
    test_saturate();
`ifdef MIPS_RUN_INST_LIMIT_EN
    test_inst_limit();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
